// File: rtl/fetch_stage.sv
// Instruction fetch front end: in-order imem requests, small instruction queue, writeback redirect.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue holds nothing filled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_pc_src,
    input  logic [31:0] wb_target_pc,
    input  logic        dec_ready,
    output logic        if_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_if,
    output logic [31:0] pc_plus_4_if,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data
);

    localparam int          PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // Handshakes: a transfer happens on a rising edge where valid && ready; a
    // valid request holds its address until accepted unless a redirect intervenes.

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] filled_q, filled_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [31:0]      ent_pc_q    [QUEUE_DEPTH];
    logic [31:0]      ent_pc_d    [QUEUE_DEPTH];
    logic [31:0]      ent_instr_q [QUEUE_DEPTH];
    logic [31:0]      ent_instr_d [QUEUE_DEPTH];

    logic [CNT_W-1:0] unfilled;
    logic [CNT_W-1:0] in_flight;
    logic [PTR_W-1:0] fill_idx;
    logic             req_fire;
    logic             rsp_fill;
    logic             rsp_drop;
    logic             head_ready;
    logic             bypass;
    logic             pop;

    // Entries fill in allocation order, so filled entries are always the
    // contiguous run starting at the head.
    always_comb begin
        unfilled   = count_q - filled_q;
        in_flight  = drop_q + unfilled;
        fill_idx   = head_q + filled_q[PTR_W-1:0];
        head_ready = (count_q != '0) && (filled_q != '0);
        rsp_fill   = imem_rsp_valid && (drop_q == '0) && (unfilled != '0);
        rsp_drop   = imem_rsp_valid && (drop_q != '0);
    end

`ifdef FETCH_BYPASS_EN
    assign bypass = !rst && !wb_pc_src && (filled_q == '0) && rsp_fill;
`else
    assign bypass = 1'b0;
`endif

    assign imem_req_valid = !rst && (count_q < CNT_W'(QUEUE_DEPTH)) &&
                            (drop_q == '0) && !wb_pc_src;
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign if_valid       = !rst && (head_ready || bypass);
    assign pop            = if_valid && dec_ready;

    always_comb begin
        instruction = NOP;
        pc_if       = pc_q;
        if (if_valid) begin
            pc_if       = ent_pc_q[head_q];
            instruction = bypass ? imem_rsp_data : ent_instr_q[head_q];
        end
        pc_plus_4_if = pc_if + 32'd4;
    end

    always_comb begin
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        filled_d    = filled_q;
        drop_d      = drop_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        if (wb_pc_src) begin
            // Flush wins over any pop; a response landing now is one fewer to drop.
            pc_d     = wb_target_pc & 32'hFFFF_FFFC;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            filled_d = '0;
            drop_d   = in_flight;
            if (imem_rsp_valid && (in_flight != '0)) begin
                drop_d = in_flight - CNT_W'(1);
            end
        end else begin
            if (rsp_drop) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (rsp_fill) begin
                ent_instr_d[fill_idx] = imem_rsp_data;
            end
            if (req_fire) begin
                ent_pc_d[tail_q] = pc_q;
                tail_d           = tail_q + PTR_W'(1);
                pc_d             = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d  = count_q + CNT_W'(req_fire) - CNT_W'(pop);
            filled_d = filled_q + CNT_W'(rsp_fill) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            filled_q <= '0;
            drop_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            filled_q <= filled_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_pc_q    <= ent_pc_d;
        ent_instr_q <= ent_instr_d;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model with variable latency,
// transaction-level expected queue, redirect/reset/stall phases plus a wrap-PC instance.
module tb_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_pc_src = 1'b0;
    logic [31:0] wb_target_pc = '0;
    logic        dec_ready = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc_if;
    logic [31:0] pc_plus_4_if;
    logic        imem_req_valid;
    logic [31:0] imem_addr;

    logic        rsp_valid_b = 1'b0;
    logic [31:0] rsp_data_b = '0;
    logic        if_valid_b;
    logic [31:0] instruction_b;
    logic [31:0] pc_if_b;
    logic [31:0] pc_plus_4_if_b;
    logic        req_valid_b;
    logic [31:0] addr_b;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wb_pc_src(wb_pc_src), .wb_target_pc(wb_target_pc),
        .dec_ready(dec_ready), .if_valid(if_valid), .instruction(instruction),
        .pc_if(pc_if), .pc_plus_4_if(pc_plus_4_if), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .wb_pc_src(1'b0), .wb_target_pc(32'h0),
        .dec_ready(1'b0), .if_valid(if_valid_b), .instruction(instruction_b),
        .pc_if(pc_if_b), .pc_plus_4_if(pc_plus_4_if_b), .imem_req_valid(req_valid_b),
        .imem_req_ready(1'b1), .imem_addr(addr_b),
        .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b)
    );

    // Expected entries: {filled, pc, instr}; memory requests: {due_cycle, addr}.
    logic [64:0] exp_q[$];
    logic [63:0] mem_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 0;
    int          m_drop = 0;
    logic [31:0] m_pc = 32'h0000_0000;
    bit          redir_pending = 1'b0;
    logic [31:0] redir_exp = '0;
    bit          acc_b_prev = 1'b0;
    logic [31:0] addr_b_prev = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[17:2] ^ 16'h5A3C};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_cycle();
        rst            = (cyc < 3) || (cyc == 400) || (cyc == 401);
        wb_pc_src      = 1'b0;
        dec_ready      = 1'b1;
        imem_req_ready = 1'b1;
        lat            = 0;
        if (cyc >= 21 && cyc <= 30) dec_ready = 1'b0;
        if (cyc >= 41 && cyc <= 58) lat = 2;
        if (cyc == 46) begin
            wb_pc_src    = 1'b1;
            wb_target_pc = 32'h0000_0102;
        end
        if (cyc >= 60 && cyc <= 64) imem_req_ready = 1'b0;
        if (cyc == 62) begin
            wb_pc_src    = 1'b1;
            wb_target_pc = 32'h0000_2000;
        end
        if (cyc >= 66 && cyc <= 75) lat = 1;
        if (cyc == 70) begin
            wb_pc_src    = 1'b1;
            wb_target_pc = 32'h0000_3000;
        end
        if (cyc == 71) begin
            wb_pc_src    = 1'b1;
            wb_target_pc = 32'h0000_4007;
        end
        if (cyc >= 80 && cyc < 400) begin
            dec_ready      = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(0, 2);
            wb_pc_src      = ($urandom_range(0, 24) == 0);
            wb_target_pc   = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : $urandom;
        end
        // Memory: in-order responses, one per cycle, none across a reset.
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rst) begin
            mem_q.delete();
        end else if (mem_q.size() > 0 && int'(mem_q[0][63:32]) <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0][31:0]);
            void'(mem_q.pop_front());
        end
        rsp_valid_b = !rst && acc_b_prev;
        rsp_data_b  = mem_word(addr_b_prev);
    endtask

    task automatic check_cycle();
        bit          hv;
        bit          byp;
        bit          ev;
        bit          erv;
        bit          acc;
        logic [64:0] e;
        hv  = (exp_q.size() > 0) && exp_q[0][64];
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = !rst && !wb_pc_src && imem_rsp_valid && (m_drop == 0) &&
              (exp_q.size() > 0) && !exp_q[0][64];
`endif
        ev  = !rst && (hv || byp);
        erv = !rst && (exp_q.size() < DEPTH) && (m_drop == 0) && !wb_pc_src;

        check_eq("if_valid", {31'b0, if_valid}, {31'b0, ev});
        check_eq("req_valid", {31'b0, imem_req_valid}, {31'b0, erv});
        check_eq("imem_addr", imem_addr, m_pc);
        if (ev) begin
            check_eq("pc_if", pc_if, exp_q[0][63:32]);
            check_eq("instruction", instruction, exp_q[0][31:0]);
            check_eq("pc_plus_4", pc_plus_4_if, exp_q[0][63:32] + 32'd4);
            if (redir_pending) begin
                check_eq("first_pc_after_redirect", pc_if, redir_exp);
                redir_pending = 1'b0;
            end
        end else begin
            check_eq("idle_instruction", instruction, NOP);
            check_eq("idle_pc_if", pc_if, m_pc);
            check_eq("idle_pc_plus_4", pc_plus_4_if, m_pc + 32'd4);
        end

        // Wrap instance: RESET_PC at the top of the address space.
        if (cyc == 3) begin
            check_eq("wrap_idle_pc_if", pc_if_b, 32'hFFFF_FFFC);
            check_eq("wrap_idle_pc_plus_4", pc_plus_4_if_b, 32'h0);
            check_eq("wrap_first_addr", addr_b, 32'hFFFF_FFFC);
        end
        if (cyc == 4) check_eq("wrap_next_addr", addr_b, 32'h0);
        if (cyc == 5) begin
            check_eq("wrap_if_valid", {31'b0, if_valid_b}, 32'h1);
            check_eq("wrap_pc_if", pc_if_b, 32'hFFFF_FFFC);
            check_eq("wrap_pc_plus_4", pc_plus_4_if_b, 32'h0);
            check_eq("wrap_instruction", instruction_b, mem_word(32'hFFFF_FFFC));
            check_eq("wrap_full_req_valid", {31'b0, req_valid_b}, 32'h0);
        end
        acc_b_prev  = !rst && req_valid_b;
        addr_b_prev = addr_b;

        // Memory reacts to what the DUT actually issued.
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back({32'(cyc + 1 + lat), imem_addr});
        end

        acc = erv && imem_req_ready;
        if (rst) begin
            exp_q.delete();
            m_pc          = 32'h0000_0000;
            m_drop        = 0;
            redir_pending = 1'b0;
        end else if (wb_pc_src) begin
            exp_q.delete();
            m_drop = mem_q.size();
            m_pc   = wb_target_pc & 32'hFFFF_FFFC;
            if (cyc == 46) begin
                redir_pending = 1'b1;
                redir_exp     = 32'h0000_0100;
            end
        end else begin
            if (imem_rsp_valid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (!exp_q[i][64]) begin
                            e        = exp_q[i];
                            e[64]    = 1'b1;
                            exp_q[i] = e;
                            break;
                        end
                    end
                end
            end
            if (ev && dec_ready) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back({1'b0, m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 450; k++) begin
            @(posedge clk);
            #1;
            cyc = k;
            drive_cycle();
            @(negedge clk);
            check_cycle();
        end
        if (redir_pending) check_eq("redirect_target_never_seen", 32'h0, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch front end that drives the decode/execute/mem/writeback pipeline and consumes its redirect.
- Keeps the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel.
- Buffers returned instructions with their PCs in a small queue and presents instruction, pc_if and pc_plus_4_if to decode under a valid/ready handshake.
- On a writeback redirect (wb_pc_src), flushes the queue, discards in-flight responses and restarts at wb_target_pc.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- QUEUE_DEPTH, 2, instruction queue entries; also the maximum in-flight requests. Power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_pc_src  input  1  redirect strobe from writeback; one-cycle pulse.
- wb_target_pc  input  32  redirect target; valid when wb_pc_src=1.
- dec_ready  input  1  decode accepts the current instruction this cycle.
- if_valid  output  1  instruction, pc_if and pc_plus_4_if are valid.
- instruction  output  32  fetched instruction word.
- pc_if  output  32  PC of the instruction.
- pc_plus_4_if  output  32  pc_if + 4.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  32  word-aligned request address.
- imem_rsp_valid  input  1  response valid; responses return in order, at least 1 cycle after acceptance, and cannot be stalled.
- imem_rsp_data  input  32  response instruction word.

Behaviour:
- Clock/reset: single clock clk; rst is synchronous, active-high. With rst high:
  - fetch PC <= RESET_PC; queue empty; in-flight count 0; drop count 0.
  - if_valid=0, imem_req_valid=0.
- Idle outputs: when if_valid=0, instruction=32'h0000_0013 (NOP), pc_if=fetch PC, pc_plus_4_if=fetch PC+4.
- Queue: each entry holds {pc, instr, filled}. An entry is allocated when a request is accepted and filled when its response arrives.
- Credit: imem_req_valid=1 iff not in reset AND allocated entries < QUEUE_DEPTH AND drop count=0 AND wb_pc_src=0.
- Request:
  - imem_addr = fetch PC.
  - When imem_req_valid && imem_req_ready: allocate the tail entry with pc=fetch PC and fetch PC += 4 (mod 2^32).
  - While a request is unaccepted, imem_addr and imem_req_valid stay stable unless a redirect occurs.
- Response: when imem_rsp_valid and drop count=0, fill the oldest unfilled entry. When drop count>0, discard the response and decrement drop count.
- Output:
  - if_valid = head entry allocated and filled.
  - instruction and pc_if come from the head entry; pc_plus_4_if = head pc + 4, 32-bit wrap (0xFFFF_FFFC gives 0).
  - if_valid && dec_ready pops the head.
  - While dec_ready=0, the outputs hold unchanged.
- Redirect (wb_pc_src=1), highest priority after rst:
  - Next edge: fetch PC <= {wb_target_pc[31:2],2'b00}; the queue is emptied.
  - Drop count <= number of requests accepted but not yet responded. A response arriving in the redirect cycle itself is discarded and not counted.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is still legal; the flush wins.
  - Back-to-back redirects: the latest target wins; drop count accumulates correctly.
- Full queue: no request issues; fetching resumes the cycle after a pop frees an entry.
- Simultaneous events: allocate, fill and pop may all happen in one cycle.
- Latency: response at edge N gives if_valid at cycle N+1 when the queue is otherwise empty.
- Reset mid-operation: all state is discarded; responses still in flight after reset must not arrive (the memory is reset together with this block).

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the queue holds no filled entry and a non-dropped response arrives for the head, instruction, pc_if and pc_plus_4_if are driven combinationally from imem_rsp_data and the head pc with if_valid=1 in the same cycle. If dec_ready=1 the entry is consumed without being stored. The redirect cycle never bypasses.
- Undefined: no combinational path from imem_rsp_* to the outputs; one-cycle queue latency as above.

Test Plan:
- Reset, RESET_PC=0, imem ready always, 1-cycle response, dec_ready=1 → imem_addr sequence 0,4,8,...; outputs pc_if 0,4,8 with pc_plus_4_if 4,8,12 and instructions matching memory contents.
- Hold dec_ready=0 from cycle 3 → exactly 2 entries fill, imem_req_valid drops to 0, outputs hold. Release → pops in order, fetching resumes.
- wb_pc_src=1, wb_target_pc=32'h0000_0102, with 2 requests in flight → both responses discarded; next imem_addr=32'h100; first valid pc_if=32'h100.
- imem_req_ready=0 for 5 cycles → imem_addr stable at the current PC, no PC advance. A redirect during this window moves imem_addr to the new target after the redirect cycle.
- RESET_PC=32'hFFFF_FFFC → pc_if=32'hFFFF_FFFC, pc_plus_4_if=0, next imem_addr=0.
- FETCH_BYPASS_EN defined, empty queue, response at cycle N → if_valid=1 in cycle N with that instruction. Undefined → if_valid first asserts in cycle N+1.
